// File: rtl/adder_accumulator_pkg.sv
// Shared definitions for the adder/accumulator datapath: default widths and
// the output mux select encodings.
package adder_accumulator_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ACC_W_DEFAULT  = 16;
    localparam int MUX_SEL_W      = 3;

    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_1     = 3'd0;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_2_LSB = 3'd1;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_2_MSB = 3'd2;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_COUNTER_VALUE  = 3'd3;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_COUNTER_CARRY  = 3'd4;

endpackage

// File: rtl/adder_accumulator_carry_counter.sv
// Counts accumulator carry-outs. The wrap flag records that the count has
// rolled over from all-ones to zero at least once and stays set until reset.
module adder_accumulator_carry_counter #(
    parameter int DATA_W = adder_accumulator_pkg::DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    output logic [DATA_W-1:0] count,
    output logic              wrap_flag
);

    logic [DATA_W-1:0] count_d, count_q;
    logic              wrap_flag_d, wrap_flag_q;

    // Next count and sticky wrap flag
    always_comb begin
        count_d     = count_q;
        wrap_flag_d = wrap_flag_q;
        if (inc) begin
            count_d = count_q + {{(DATA_W-1){1'b0}}, 1'b1};
            if (&count_q) begin
                wrap_flag_d = 1'b1;
            end
        end
    end

    // Counter state with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            wrap_flag_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrap_flag_q <= wrap_flag_d;
        end
    end

    assign count     = count_q;
    assign wrap_flag = wrap_flag_q;

endmodule

// File: rtl/adder_accumulator.sv
// Operand register feeding a double-width accumulator. Accumulator carry-outs
// are counted, and a select input exposes any internal value on data_out.
// ACC_W is expected to be 2*DATA_W so the accumulator splits into two bytes.
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 add,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [MUX_SEL_W-1:0] output_sel,
    output logic [DATA_W-1:0]    data_out
);

    logic [DATA_W-1:0] reg1_d, reg1_q;
    logic [ACC_W-1:0]  reg2_d, reg2_q;
    logic [ACC_W:0]    sum;
    logic              carry_inc;
    logic [DATA_W-1:0] carry_count;
    logic              carry_wrap;

    // Adder and next-state selection; add reads the pre-edge operand so a
    // simultaneous load does not affect the sum at the same edge
    always_comb begin
        sum       = {1'b0, reg2_q} + {{(ACC_W-DATA_W+1){1'b0}}, reg1_q};
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        carry_inc = 1'b0;
        if (load) begin
            reg1_d = data_in;
        end
        if (add) begin
            reg2_d    = sum[ACC_W-1:0];
            carry_inc = sum[ACC_W];
        end
    end

    // Operand and accumulator registers with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            reg1_q <= '0;
            reg2_q <= '0;
        end else begin
            reg1_q <= reg1_d;
            reg2_q <= reg2_d;
        end
    end

    adder_accumulator_carry_counter #(
        .DATA_W(DATA_W)
    ) u_carry_counter (
        .clock    (clock),
        .reset    (reset),
        .inc      (carry_inc),
        .count    (carry_count),
        .wrap_flag(carry_wrap)
    );

    // Output mux; unused select codes read as zero
    always_comb begin
        data_out = '0;
        case (output_sel)
            MUX_SEL_REGISTER_1:     data_out = reg1_q;
            MUX_SEL_REGISTER_2_LSB: data_out = reg2_q[DATA_W-1:0];
            MUX_SEL_REGISTER_2_MSB: data_out = reg2_q[2*DATA_W-1:DATA_W];
            MUX_SEL_COUNTER_VALUE:  data_out = carry_count;
            MUX_SEL_COUNTER_CARRY:  data_out = {{(DATA_W-1){1'b0}}, carry_wrap};
            default:                data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Testbench for adder_accumulator: directed scenarios plus a randomized
// phase, checked against an arithmetic model of the running total.
module tb_adder_accumulator;

    logic       clock;
    logic       reset;
    logic       load;
    logic       add;
    logic [7:0] data_in;
    logic [2:0] output_sel;
    logic [7:0] data_out;

    int pass_cnt;
    int chk_cnt;

    // Model: operand value and the unbounded sum of everything accumulated
    // since the last reset. Register_2, the carry count and the wrap flag
    // all follow from that total.
    logic [7:0] r1_m;
    longint     total_m;

    adder_accumulator dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .add       (add),
        .data_in   (data_in),
        .output_sel(output_sel),
        .data_out  (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model_out(input logic [2:0] s);
        longint wraps;
        longint acc;
        wraps = total_m / 65536;
        acc   = total_m % 65536;
        case (s)
            3'd0:    return r1_m;
            3'd1:    return 8'(acc % 256);
            3'd2:    return 8'(acc / 256);
            3'd3:    return 8'(wraps % 256);
            3'd4:    return (wraps >= 256) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One clock edge with the given strobes, then model update
    task automatic step(input logic rs, input logic ld, input logic ad, input logic [7:0] din);
        @(negedge clock);
        reset   = rs;
        load    = ld;
        add     = ad;
        data_in = din;
        @(posedge clock);
        if (rs) begin
            r1_m    = 8'h00;
            total_m = 0;
        end else begin
            if (ad) total_m = total_m + longint'(r1_m);
            if (ld) r1_m = din;
        end
        @(negedge clock);
        reset = 1'b0;
        load  = 1'b0;
        add   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [2:0] s);
        logic [7:0] exp;
        @(negedge clock);
        output_sel = s;
        #1;
        exp = model_out(s);
        chk_cnt = chk_cnt + 1;
        assert (data_out === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s sel=%0d: got %h expected %h", tag, s, data_out, exp);
    endtask

    task automatic check_lit(input string tag, input logic [2:0] s, input logic [7:0] exp);
        @(negedge clock);
        output_sel = s;
        #1;
        chk_cnt = chk_cnt + 1;
        assert (data_out === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s sel=%0d: got %h expected %h", tag, s, data_out, exp);
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < 8; s++) check(tag, 3'(s));
    endtask

    initial begin
        pass_cnt   = 0;
        chk_cnt    = 0;
        reset      = 1'b1;
        load       = 1'b0;
        add        = 1'b0;
        data_in    = 8'h00;
        output_sel = 3'd0;
        r1_m       = 8'h00;
        total_m    = 0;

        // Reset: every select reads zero
        step(1, 0, 0, 8'h00);
        for (int s = 0; s < 8; s++) check_lit("reset", 3'(s), 8'h00);

        // Load then hold against a changing data_in
        step(0, 1, 0, 8'h42);
        check_lit("load", 3'd0, 8'h42);
        step(0, 0, 0, 8'hFF);
        check_lit("hold", 3'd0, 8'h42);

        // Accumulate 0x42 + 0xEE
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h42);
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'hEE);
        step(0, 0, 1, 8'h00);
        check_lit("acc_lsb", 3'd1, 8'h30);
        check_lit("acc_msb", 3'd2, 8'h01);
        check_lit("acc_cnt", 3'd3, 8'h00);

        // 300 iterations of (load 0xFE, add): one wrap
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 8'hFE);
            step(0, 0, 1, 8'h00);
        end
        check_lit("wrap_msb", 3'd2, 8'h2A);
        check_lit("wrap_lsb", 3'd1, 8'hD8);
        check_lit("wrap_cnt", 3'd3, 8'h01);
        check_lit("wrap_flag", 3'd4, 8'h00);
        check_all("wrap_model");
        step(1, 0, 0, 8'h00);
        for (int s = 0; s < 8; s++) check_lit("rst_after_wrap", 3'(s), 8'h00);

        // Simultaneous load and add uses the old operand
        step(0, 1, 0, 8'h10);
        step(0, 1, 1, 8'h20);
        check_lit("sim_lsb", 3'd1, 8'h10);
        check_lit("sim_msb", 3'd2, 8'h00);
        check_lit("sim_r1", 3'd0, 8'h20);

        // Reset wins over strobes
        step(1, 1, 1, 8'h77);
        check_all("rst_override");

        // Counter overflow: 256 carry-outs with repeated adds of 0xFF
        step(0, 1, 0, 8'hFF);
        while ((total_m / 65536) < 256) step(0, 0, 1, 8'h00);
        check_lit("ovf_cnt", 3'd3, 8'h00);
        check_lit("ovf_flag", 3'd4, 8'h01);
        for (int i = 0; i < 600; i++) step(0, 0, 1, 8'h00);
        check_lit("ovf_sticky", 3'd4, 8'h01);
        check_all("ovf_model");
        step(1, 0, 0, 8'h00);
        check_lit("ovf_cleared", 3'd4, 8'h00);

        // Randomized strobes and data, occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
            check("rand", 3'($urandom));
        end
        check_all("rand_final");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
